// File: rtl/mole_sequencer.sv
// mole_sequencer: whack-a-mole game sequencer.
// Picks a pseudo-random hole and asks the rectangle drawer to redraw the screen.
// It then shows the mole for TICKS_UP cycles and scores either a hit or a miss
// from rising edges on the player inputs.
// Optional feature macro WRONG_WHACK_PENALTY_EN: when defined, an edge on a wrong
// hole during SHOW, with no edge on the mole's hole, counts as a miss.
//
// state | meaning
// IDLE  | waiting for start
// PICK  | choose next hole from the LFSR, avoiding an immediate repeat
// DRAW  | one draw_rst_n cycle, then DRAW_CYCLES cycles of plot
// SHOW  | mole visible, countdown running, watching for whacks
// HIT   | score the hit and clear the mole
// MISS  | count the miss and clear the mole
// OVER  | game finished, held until reset
module mole_sequencer #(
  parameter int TICKS_UP    = 50000000,
  parameter int DRAW_CYCLES = 160000,
  parameter int MAX_MISSES  = 3
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] whack,
  output logic [7:0] hole,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [8:0] L,
  output logic [7:0] W,
  output logic       plot,
  output logic       draw_rst_n,
  output logic [7:0] score,
  output logic [1:0] misses,
  output logic       game_over
);

  localparam int CNT_MAX = (TICKS_UP > DRAW_CYCLES) ? TICKS_UP : DRAW_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHOW_LOAD = CW'(TICKS_UP - 1);
  localparam logic [CW-1:0] DRAW_LOAD = CW'(DRAW_CYCLES - 1);
  localparam logic [1:0]    MISS_LIM  = 2'(MAX_MISSES);

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_DRAW, S_SHOW, S_HIT, S_MISS, S_OVER
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    lfsr;
  logic [7:0]    whack_q;
  logic [2:0]    idx;
  logic [2:0]    pick_idx;
  logic [CW-1:0] cnt;
  logic          show_after;
  logic [7:0]    edges;
  logic [7:0]    idx_hot;
  logic          hit;
  logic          draw_first;
  logic          draw_done;
  logic [1:0]    misses_inc;

  // Full-screen region handed to the drawer never changes.
  assign x = 9'd0;
  assign y = 8'd0;
  assign L = 9'd319;
  assign W = 8'd239;

  assign edges      = whack & ~whack_q;
  assign idx_hot    = 8'd1 << idx;
  assign hit        = |(edges & idx_hot);
  assign pick_idx   = (lfsr[2:0] == idx) ? lfsr[2:0] + 3'd1 : lfsr[2:0];
  // draw_rst_n is low only on the first DRAW cycle, so it marks that cycle.
  assign draw_first = (state == S_DRAW) && !draw_rst_n;
  assign draw_done  = (state == S_DRAW) && draw_rst_n && (cnt == '0);
  assign misses_inc = misses + 2'd1;

`ifdef WRONG_WHACK_PENALTY_EN
  logic wrong;
  assign wrong = |(edges & ~idx_hot);
`endif

  // State register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; a hit on the mole's hole takes priority over timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_PICK;
      S_PICK: state_nxt = S_DRAW;
      S_DRAW: if (draw_done) state_nxt = show_after ? S_SHOW : S_PICK;
      S_SHOW: begin
        if (hit) state_nxt = S_HIT;
`ifdef WRONG_WHACK_PENALTY_EN
        else if (wrong) state_nxt = S_MISS;
`endif
        else if (cnt == '0) state_nxt = S_MISS;
      end
      S_HIT:  state_nxt = S_DRAW;
      S_MISS: state_nxt = (misses_inc == MISS_LIM) ? S_OVER : S_DRAW;
      S_OVER: state_nxt = S_OVER;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; plot follows the draw_rst_n cycle.
  always_comb begin
    plot      = 1'b0;
    game_over = 1'b0;
    case (state)
      S_DRAW:  plot = draw_rst_n;
      S_OVER:  game_over = 1'b1;
      default: ;
    endcase
  end

  // Datapath: LFSR, whack history, hole choice, timer, score and misses.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      lfsr       <= 8'hA5;
      whack_q    <= 8'd0;
      idx        <= 3'd0;
      hole       <= 8'd0;
      cnt        <= '0;
      show_after <= 1'b0;
      score      <= 8'd0;
      misses     <= 2'd0;
      draw_rst_n <= 1'b0;
    end else begin
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      whack_q    <= whack;
      draw_rst_n <= !((state_nxt == S_DRAW) && (state != S_DRAW));
      case (state)
        S_PICK: begin
          idx        <= pick_idx;
          hole       <= 8'd1 << pick_idx;
          show_after <= 1'b1;
        end
        S_DRAW: begin
          if (draw_first)      cnt <= DRAW_LOAD;
          else if (cnt == '0)  cnt <= SHOW_LOAD;
          else                 cnt <= cnt - CW'(1);
        end
        S_SHOW: if (cnt != '0) cnt <= cnt - CW'(1);
        S_HIT: begin
          if (score != 8'hFF) score <= score + 8'd1;
          hole       <= 8'd0;
          show_after <= 1'b0;
        end
        S_MISS: begin
          misses <= misses_inc;
          hole   <= 8'd0;
          if (misses_inc != MISS_LIM) show_after <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_sequencer.sv
// tb_mole_sequencer: randomized self-checking bench for mole_sequencer.
// The reference model tracks the game at the round level.
// Expected hole choices come from the LFSR rule; exit timing comes from the
// show-window length and the hit/miss rules.
module tb_mole_sequencer;
  localparam int TICKS = 20;
  localparam int DRAWC = 10;
  localparam int MAXM  = 3;

  logic       clock = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic [7:0] whack = 8'd0;
  logic [7:0] hole;
  logic [8:0] x;
  logic [7:0] y;
  logic [8:0] L;
  logic [7:0] W;
  logic       plot, draw_rst_n, game_over;
  logic [7:0] score;
  logic [1:0] misses;

  int checks   = 0;
  int failures = 0;

  // model state
  logic [7:0] m_lfsr, m_lfsr_prev;
  logic [2:0] prev_idx;
  int         exp_score, exp_misses;

  mole_sequencer #(.TICKS_UP(TICKS), .DRAW_CYCLES(DRAWC), .MAX_MISSES(MAXM)) dut (
    .clock(clock), .rst(rst), .start(start), .whack(whack), .hole(hole),
    .x(x), .y(y), .L(L), .W(W), .plot(plot), .draw_rst_n(draw_rst_n),
    .score(score), .misses(misses), .game_over(game_over)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // reference LFSR sequence, restarted by reset
  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      m_lfsr      <= 8'hA5;
      m_lfsr_prev <= 8'hA5;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= lfsr_step(m_lfsr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hole"}, hole, 0);
    chk({tag, "_plot"}, plot, 0);
    chk({tag, "_drn"}, draw_rst_n, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_misses"}, misses, 0);
    chk({tag, "_over"}, game_over, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0; start = 1'b0; whack = 8'd0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clock);
    rst = 1'b1;
    prev_idx = 3'd0; exp_score = 0; exp_misses = 0;
    @(negedge clock);
    chk("rel_drn", draw_rst_n, 1);
    chk("rel_plot", plot, 0);
    chk("rel_hole", hole, 0);
  endtask

  task automatic start_game();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // Waits for the draw_rst_n cycle, checks the hole, counts plot cycles.
  task automatic run_draw(input bit pick);
    int n;
    logic [2:0] e_idx;
    n = 0;
    while (draw_rst_n !== 1'b0 && n < 50) begin @(negedge clock); n++; end
    chk("draw_rst_lo", draw_rst_n, 0);
    chk("draw_first_plot", plot, 0);
    if (pick) begin
      e_idx = (m_lfsr_prev[2:0] == prev_idx) ? m_lfsr_prev[2:0] + 3'd1 : m_lfsr_prev[2:0];
      chk("pick_hole", hole, 8'd1 << e_idx);
      chk("pick_repeat", hole == (8'd1 << prev_idx), 0);
      prev_idx = e_idx;
    end else begin
      chk("draw_hole_clr", hole, 0);
    end
    @(negedge clock);
    n = 0;
    while (plot === 1'b1 && n < 200) begin n++; @(negedge clock); end
    chk("plot_len", n, DRAWC);
  endtask

  // Entered on the first SHOW cycle; drives an optional whack and checks outcome.
  task automatic show_phase(input int hit_at, input logic [7:0] pattern);
    int c, exp_c;
    bit e_hit, e_miss;
    chk("show_hole", hole, 8'd1 << prev_idx);
    chk("show_plot", plot, 0);
    c = 0;
    while (c < 100) begin
      if (draw_rst_n === 1'b0 || game_over === 1'b1) break;
      if (c == hit_at) whack = pattern;
      if (hit_at >= 0 && c == hit_at + 1) whack = 8'd0;
      @(negedge clock);
      c++;
    end
    e_hit  = (hit_at >= 0) && pattern[prev_idx];
    e_miss = !e_hit;
    exp_c  = TICKS + 1;
    if (e_hit) exp_c = hit_at + 2;
`ifdef WRONG_WHACK_PENALTY_EN
    if (!e_hit && hit_at >= 0 && pattern != 8'd0) exp_c = hit_at + 2;
`endif
    if (e_hit && exp_score < 255) exp_score++;
    if (e_miss) exp_misses++;
    chk("exit_cycle", c, exp_c);
    chk("score", score, exp_score);
    chk("misses", misses, exp_misses);
    chk("exit_hole", hole, 0);
    chk("game_over", game_over, exp_misses >= MAXM);
  endtask

  // kind: 0 hit (idx plus random extras), 1 no whack, 2 wrong holes, 3 held high
  task automatic round(input int kind, input int hit_at);
    logic [7:0] pat, hot;
    if (kind == 3) whack = 8'hFF;
    run_draw(1);
    hot = 8'd1 << prev_idx;
    case (kind)
      0: pat = hot | 8'($urandom_range(0, 255));
      2: begin
        pat = 8'($urandom_range(1, 255)) & ~hot;
        if (pat == 8'd0) pat = ~hot;
      end
      default: pat = 8'd0;
    endcase
    show_phase((kind == 0 || kind == 2) ? hit_at : -1, pat);
    whack = 8'd0;
    if (game_over !== 1'b1) run_draw(0);
  endtask

  initial begin
    // game 1: hits incl. boundaries, then three misses to game over
    do_reset();
    chk("x", x, 0); chk("y", y, 0); chk("L", L, 319); chk("W", W, 239);
    start_game();
    round(0, 5);
    round(0, TICKS - 1);
    round(0, 0);
    for (int i = 0; i < 3; i++) round(0, $urandom_range(0, TICKS - 1));
    round(3, 0);
    round(2, $urandom_range(0, TICKS - 2));
    while (game_over !== 1'b1 && exp_misses < MAXM) round(1, 0);
    @(negedge clock); start = 1'b1;
    repeat (5) @(negedge clock);
    start = 1'b0;
    chk("over_hold", game_over, 1);
    chk("over_hole", hole, 0);
    chk("over_plot", plot, 0);
    chk("over_drn", draw_rst_n, 1);
    chk("over_misses", misses, MAXM);

    // game 2: reset mid-SHOW with score 4
    do_reset();
    start_game();
    for (int i = 0; i < 4; i++) round(0, $urandom_range(0, TICKS - 1));
    chk("pre_rst_score", score, 4);
    run_draw(1);
    repeat (7) @(negedge clock);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_show");
    repeat (2) @(negedge clock);
    rst = 1'b1;
    prev_idx = 3'd0; exp_score = 0; exp_misses = 0;
    @(negedge clock);
    chk("post_drn", draw_rst_n, 1);
    repeat (3) @(negedge clock);
    chk("idle_plot", plot, 0);
    chk("idle_hole", hole, 0);

    // game 3: long random hit run to saturate the score
    start_game();
    for (int i = 0; i < 258; i++) round(0, $urandom_range(0, TICKS - 1));
    chk("score_sat", score, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mole_sequencer.md
MOLE_SEQUENCER -- requirements
Module: mole_sequencer

Interface
REQ-001 Parameter TICKS_UP, default 50000000; mole visible time in clock cycles.
REQ-002 Parameter DRAW_CYCLES, default 160000; cycles allotted to one full-screen rectangle redraw.
REQ-003 Parameter MAX_MISSES, default 3; misses that end the game.
REQ-004 Port clock  in  1  system clock. Single clock; all state on rising edge.
REQ-005 Port rst  in  1  asynchronous active-low reset.
REQ-006 Port start  in  1  level; begins a game from IDLE.
REQ-007 Port whack  in  8  synchronised player inputs, bit n targets hole n.
REQ-008 Port hole  out  8  one-hot mole pattern to the drawer; 0 = no mole.
REQ-009 Port x, y, L, W  out  9/8/9/8  drawer region, constants 0, 0, 319, 239.
REQ-010 Port plot  out  1  high while the drawer output is being written to the VGA adapter.
REQ-011 Port draw_rst_n  out  1  active-low restart strobe to the drawer FSM.
REQ-012 Port score  out  8  hits, saturating at 255.
REQ-013 Port misses  out  2  missed moles.
REQ-014 Port game_over  out  1  high once misses reach MAX_MISSES.

Function
REQ-015 The FSM SHALL have states IDLE, PICK, DRAW, SHOW, HIT, MISS, OVER.
REQ-016 An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5) SHALL advance every cycle in every state.
REQ-017 IDLE: stay while start=0; start=1 -> PICK next cycle.
REQ-018 PICK (1 cycle): idx=lfsr[2:0]; if idx equals previous idx, use (idx+1) mod 8; hole <= one-hot(idx); set show_after=1; -> DRAW.
REQ-019 DRAW: draw_rst_n SHALL be 0 on the first DRAW cycle only; plot SHALL be 1 for exactly DRAW_CYCLES cycles starting the cycle after; then -> SHOW if show_after=1, else -> PICK.
REQ-020 SHOW: countdown loaded with TICKS_UP-1 on entry, decremented each cycle; plot=0.
REQ-021 Whack detection SHALL use rising edges of whack (registered previous value, updated every cycle in all states).
REQ-022 In SHOW, a rising edge on whack[idx] -> HIT; countdown at 0 with no such edge -> MISS.
REQ-023 Hit edge and countdown=0 in the same cycle SHALL resolve as HIT; multiple edges including idx SHALL resolve as HIT.
REQ-024 Rising edges outside SHOW SHALL be ignored.
REQ-025 HIT (1 cycle): score <= score+1 (hold at 255); hole <= 0; show_after=0; -> DRAW.
REQ-026 MISS (1 cycle): misses <= misses+1; hole <= 0; if new misses = MAX_MISSES -> OVER, else show_after=0, -> DRAW.
REQ-027 OVER: game_over=1, hole=0, plot=0; remain until reset.
REQ-028 Counters SHALL be sized to hold max(TICKS_UP, DRAW_CYCLES) without wrap.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, hole 0, plot 0, draw_rst_n 0, score 0, misses 0, game_over 0, LFSR 8'hA5, previous idx 0, counters 0, whack history 0.
REQ-030 Reset mid-DRAW or mid-SHOW SHALL abandon the operation with no partial score/miss update; draw_rst_n returns to 1 the first clock after release.

Configuration
REQ-031 Macro WRONG_WHACK_PENALTY_EN: when defined, a rising edge in SHOW on any whack bit other than idx, with no edge on idx, SHALL go to MISS; when undefined such edges SHALL be ignored.

Verification (TICKS_UP=20, DRAW_CYCLES=10, MAX_MISSES=3)
REQ-032 Reset release, start=1 one cycle -> PICK, hole one-hot, draw_rst_n low 1 cycle, plot high exactly 10 cycles, then SHOW.
REQ-033 In SHOW, pulse whack[idx] at cycle 5 -> score 0->1, hole=0, plot 10 cycles, new hole with idx different from previous.
REQ-034 No whack for 20 SHOW cycles three times -> misses 1,2,3, game_over=1, hole=0, start ignored.
REQ-035 whack[idx] edge on countdown-0 cycle -> HIT, misses unchanged; whack held high from DRAW into SHOW -> no hit (no edge).
REQ-036 Wrong-hole edge: with WRONG_WHACK_PENALTY_EN -> misses+1; without -> no change, mole stays full 20 cycles.
REQ-037 Assert rst mid-SHOW with score=4 -> all outputs at reset values within the same cycle, IDLE after release.
